// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: assembles UART receiver bytes into command frames and
// issues single-cycle register-file write/read and ALU strobes. An
// inter-byte timeout abandons stalled frames and returns to IDLE.
module rx_cmd_decoder #(
    parameter int          ADDR_W      = 4,
    parameter int          TIMEOUT_CYC = 4096,
    parameter logic [7:0]  CMD_WR      = 8'hAA,
    parameter logic [7:0]  CMD_RD      = 8'hBB,
    parameter logic [7:0]  CMD_ALU_OP  = 8'hCC,
    parameter logic [7:0]  CMD_ALU_NOP = 8'hDD
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              rx_d_valid,
    input  logic [7:0]        rx_p_data,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wr_data,
    output logic              alu_en,
    output logic [3:0]        alu_fun,
    output logic              cmd_err,
    output logic              frame_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        ALU_A,
        ALU_B,
        ALU_FUN
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic               tmo_expire;
    logic [ADDR_W-1:0]  waddr_q;

    logic               wr_en_q, rd_en_q, alu_en_q, cmd_err_q, frame_err_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         wr_data_q;
    logic [3:0]         alu_fun_q;

    // Inter-byte timer: idle in IDLE, restarted by every accepted byte; a byte
    // landing on the expiry cycle wins over the timeout.
    always_comb begin
        tmo_d      = tmo_q;
        tmo_expire = 1'b0;
        if (rx_d_valid || state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d      = '0;
            tmo_expire = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end

    // Frame FSM with registered strobes; addr/wr_data/alu_fun hold between strobes.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            alu_fun_q   <= '0;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_d_valid) begin
                case (state_q)
                    IDLE: begin
                        if      (rx_p_data == CMD_WR)      state_q <= WR_ADDR;
                        else if (rx_p_data == CMD_RD)      state_q <= RD_ADDR;
                        else if (rx_p_data == CMD_ALU_OP)  state_q <= ALU_A;
                        else if (rx_p_data == CMD_ALU_NOP) state_q <= ALU_FUN;
                        else                               cmd_err_q <= 1'b1;
                    end
                    WR_ADDR: begin
                        waddr_q <= rx_p_data[ADDR_W-1:0];
                        state_q <= WR_DATA;
                    end
                    WR_DATA: begin
                        wr_en_q   <= 1'b1;
                        addr_q    <= waddr_q;
                        wr_data_q <= rx_p_data;
                        state_q   <= IDLE;
                    end
                    RD_ADDR: begin
                        rd_en_q <= 1'b1;
                        addr_q  <= rx_p_data[ADDR_W-1:0];
                        state_q <= IDLE;
                    end
                    // Operands land in register-file slots 0 and 1.
                    ALU_A: begin
                        wr_en_q   <= 1'b1;
                        addr_q    <= ADDR_W'(0);
                        wr_data_q <= rx_p_data;
                        state_q   <= ALU_B;
                    end
                    ALU_B: begin
                        wr_en_q   <= 1'b1;
                        addr_q    <= ADDR_W'(1);
                        wr_data_q <= rx_p_data;
                        state_q   <= ALU_FUN;
                    end
                    ALU_FUN: begin
                        alu_en_q  <= 1'b1;
                        alu_fun_q <= rx_p_data[3:0];
                        state_q   <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (tmo_expire) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign alu_en    = alu_en_q;
    assign cmd_err   = cmd_err_q;
    assign frame_err = frame_err_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign alu_fun   = alu_fun_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Scoreboard bench for rx_cmd_decoder: expected strobes (with their cycle)
// are queued as frames are driven and popped when the DUT strobes.
module tb_rx_cmd_decoder;

    localparam int ADDR_W = 4;
    localparam int TO     = 16;

    localparam logic [4:0] K_WR = 5'b10000;
    localparam logic [4:0] K_RD = 5'b01000;
    localparam logic [4:0] K_AL = 5'b00100;
    localparam logic [4:0] K_CE = 5'b00010;
    localparam logic [4:0] K_FE = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] kind;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rest = 1'b1;
    logic              rx_d_valid = 1'b0;
    logic [7:0]        rx_p_data = 8'h00;
    logic              wr_en, rd_en, alu_en, cmd_err, frame_err;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wr_data;
    logic [3:0]        alu_fun;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_on = 1'b0;
    exp_t sb[$];

    logic [3:0] h_addr = '0;
    logic [7:0] h_data = '0;
    logic [3:0] h_fun  = '0;

    rx_cmd_decoder #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rest       (rest),
        .rx_d_valid (rx_d_valid),
        .rx_p_data  (rx_p_data),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .alu_en     (alu_en),
        .alu_fun    (alu_fun),
        .cmd_err    (cmd_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Byte is accepted on the posedge after this negedge; returns that edge's cycle.
    task automatic drive_byte(input logic [7:0] b, output int acc);
        @(negedge clk);
        rx_d_valid = 1'b1;
        rx_p_data  = b;
        acc        = cyc + 1;
        @(posedge clk);
        #1;
        rx_d_valid = 1'b0;
        rx_p_data  = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [4:0] k, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard; held
    // outputs must match the last values the scoreboard implies.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [4:0] k;
            exp_t e;
            k = {wr_en, rd_en, alu_en, cmd_err, frame_err};
            if (k != 5'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 32'(k), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    chk("strobe_kind", 32'(k), 32'(e.kind));
                    if (e.kind == K_WR) begin h_addr = e.addr; h_data = e.data; end
                    if (e.kind == K_RD) h_addr = e.addr;
                    if (e.kind == K_AL) h_fun = e.data[3:0];
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                chk("missing_strobe", 32'h0, 32'(sb[0].kind));
                void'(sb.pop_front());
            end
            chk("addr", 32'(addr), 32'(h_addr));
            chk("wr_data", 32'(wr_data), 32'(h_data));
            chk("alu_fun", 32'(alu_fun), 32'(h_fun));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, 32'({wr_en, rd_en, alu_en, cmd_err, frame_err}), 32'h0);
        chk({tag, "_addr"}, 32'(addr), 32'h0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'h0);
        chk({tag, "_alu_fun"}, 32'(alu_fun), 32'h0);
    endtask

    initial begin
        int a;
        int a0;

        // Reset state
        idle(2);
        chk_all_zero("reset");
        @(posedge clk); #1 rest = 1'b0;
        mon_on = 1'b1;
        idle(2);

        // Register write
        drive_byte(8'hAA, a); drive_byte(8'h05, a); drive_byte(8'h3C, a);
        push(a, K_WR, 4'h5, 8'h3C);
        idle(3);

        // Register read, address from low bits
        drive_byte(8'hBB, a); drive_byte(8'h1A, a);
        push(a, K_RD, 4'hA, 8'h00);
        idle(3);

        // ALU with operands, back-to-back
        drive_byte(8'hCC, a);
        drive_byte(8'h11, a); push(a, K_WR, 4'h0, 8'h11);
        drive_byte(8'h22, a); push(a, K_WR, 4'h1, 8'h22);
        drive_byte(8'h07, a); push(a, K_AL, 4'h0, 8'h07);
        idle(3);

        // ALU without operands, then unknown opcode, then a normal frame
        drive_byte(8'hDD, a); drive_byte(8'h03, a);
        push(a, K_AL, 4'h0, 8'h03);
        drive_byte(8'h55, a); push(a, K_CE, 4'h0, 8'h00);
        drive_byte(8'hAA, a); drive_byte(8'h07, a); drive_byte(8'h99, a);
        push(a, K_WR, 4'h7, 8'h99);
        idle(3);

        // Timeout after opcode, then a read decodes normally
        drive_byte(8'hAA, a);
        push(a + TO, K_FE, 4'h0, 8'h00);
        idle(TO + 3);
        drive_byte(8'hBB, a); drive_byte(8'h02, a);
        push(a, K_RD, 4'h2, 8'h00);
        idle(3);

        // Byte on the expiry cycle is accepted
        drive_byte(8'hAA, a0);
        idle(TO - 1);
        drive_byte(8'h05, a);
        chk("expiry_edge_alignment", 32'(a - a0), 32'(TO));
        drive_byte(8'h3C, a);
        push(a, K_WR, 4'h5, 8'h3C);
        idle(TO + 3);

        // Partial ALU frame: operand write stays, then timeout
        drive_byte(8'hCC, a);
        drive_byte(8'h11, a); push(a, K_WR, 4'h0, 8'h11);
        push(a + TO, K_FE, 4'h0, 8'h00);
        idle(TO + 3);

        // Opcode values inside a frame are data
        drive_byte(8'hAA, a); drive_byte(8'hBB, a); drive_byte(8'hCC, a);
        push(a, K_WR, 4'hB, 8'hCC);
        idle(3);

        // Reset mid-frame discards it; next byte is parsed as an opcode
        drive_byte(8'hAA, a); drive_byte(8'h05, a);
        @(posedge clk); #1 rest = 1'b1;
        h_addr = '0; h_data = '0; h_fun = '0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        @(posedge clk); #1 rest = 1'b0;
        drive_byte(8'h3C, a); push(a, K_CE, 4'h0, 8'h00);
        idle(TO + 3);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
